// File: rtl/pipeline_run_controller.sv
// Run/step/halt sequencer producing the pipeline advance enable.
// Optional cycle counter: define PIPELINE_RUN_CYCLE_COUNTER_EN.
module pipeline_run_controller #(
  parameter int NB_CMD   = 2,
  parameter int NB_STEP  = 8,
  parameter int NB_CYCLE = 32,
  parameter int N_DRAIN  = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [NB_CMD-1:0]   i_cmd,
  input  logic [NB_STEP-1:0]  i_step_count,
  input  logic                i_halt_detected,
  output logic                o_cmd_ready,
  output logic                o_valid,
  output logic                o_pipe_reset,
  output logic                o_done,
  output logic                o_halted,
  output logic [2:0]          o_state,
  output logic [NB_CYCLE-1:0] o_cycle_count
);

  localparam int NB_DRAIN = $clog2(N_DRAIN + 1);

  localparam logic [NB_CMD-1:0] CMD_CLEAR = NB_CMD'(0);
  localparam logic [NB_CMD-1:0] CMD_RUN   = NB_CMD'(1);
  localparam logic [NB_CMD-1:0] CMD_STEP  = NB_CMD'(2);
  localparam logic [NB_CMD-1:0] CMD_STOP  = NB_CMD'(3);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t              state;
  logic [NB_STEP-1:0]  step_cnt;
  logic [NB_DRAIN-1:0] drain_cnt;
  logic                accept;
  logic [NB_STEP-1:0]  step_ld;

  assign o_cmd_ready = (state == S_IDLE) ||
                       (state == S_RUN)  ||
                       (state == S_HALTED);
  assign accept  = i_cmd_valid && o_cmd_ready;
  assign o_state = state;
  assign step_ld = (i_step_count == '0) ? NB_STEP'(1) : i_step_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      step_cnt     <= '0;
      drain_cnt    <= '0;
      o_valid      <= 1'b0;
      o_pipe_reset <= 1'b0;
      o_done       <= 1'b0;
      o_halted     <= 1'b0;
    end else begin
      o_pipe_reset <= 1'b0;
      o_done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            unique case (i_cmd)
              CMD_RUN: begin
                state   <= S_RUN;
                o_valid <= 1'b1;
              end
              CMD_STEP: begin
                state    <= S_STEP;
                step_cnt <= step_ld;
                o_valid  <= 1'b1;
              end
              CMD_CLEAR: o_pipe_reset <= 1'b1;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // Halt wins over a STOP offered in the same cycle.
          if (i_halt_detected) begin
            state     <= S_DRAIN;
            drain_cnt <= NB_DRAIN'(N_DRAIN);
          end else if (accept && i_cmd == CMD_STOP) begin
            state   <= S_IDLE;
            o_valid <= 1'b0;
          end
        end
        S_STEP: begin
          if (i_halt_detected) begin
            state     <= S_DRAIN;
            step_cnt  <= '0;
            drain_cnt <= NB_DRAIN'(N_DRAIN);
          end else if (step_cnt <= NB_STEP'(1)) begin
            state    <= S_IDLE;
            step_cnt <= '0;
            o_valid  <= 1'b0;
            o_done   <= 1'b1;
          end else begin
            step_cnt <= step_cnt - NB_STEP'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt <= NB_DRAIN'(1)) begin
            state     <= S_HALTED;
            drain_cnt <= '0;
            o_valid   <= 1'b0;
            o_done    <= 1'b1;
            o_halted  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - NB_DRAIN'(1);
          end
        end
        S_HALTED: begin
          if (accept && i_cmd == CMD_CLEAR) begin
            state        <= S_IDLE;
            o_halted     <= 1'b0;
            o_pipe_reset <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          o_valid  <= 1'b0;
          o_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPELINE_RUN_CYCLE_COUNTER_EN
  logic [NB_CYCLE-1:0] cycle_cnt;
  logic                cnt_clr;

  assign cnt_clr = accept && (i_cmd == CMD_CLEAR) &&
                   ((state == S_IDLE) || (state == S_HALTED));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cycle_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
    end else if (o_valid && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + NB_CYCLE'(1);
    end
  end

  assign o_cycle_count = cycle_cnt;
`else
  assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench for pipeline_run_controller.
// Vector table fed through an expectation queue, plus reset sequences.
module tb_pipeline_run_controller;

  localparam int NB_CYCLE = 4;
`ifdef PIPELINE_RUN_CYCLE_COUNTER_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam bit [1:0] C_CLEAR = 2'd0;
  localparam bit [1:0] C_RUN   = 2'd1;
  localparam bit [1:0] C_STEP  = 2'd2;
  localparam bit [1:0] C_STOP  = 2'd3;

  logic                i_clock = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_cmd_valid = 1'b0;
  logic [1:0]          i_cmd = 2'd0;
  logic [7:0]          i_step_count = 8'd0;
  logic                i_halt_detected = 1'b0;
  logic                o_cmd_ready;
  logic                o_valid;
  logic                o_pipe_reset;
  logic                o_done;
  logic                o_halted;
  logic [2:0]          o_state;
  logic [NB_CYCLE-1:0] o_cycle_count;

  int checks = 0;
  int failures = 0;

  pipeline_run_controller #(
    .NB_CMD(2), .NB_STEP(8), .NB_CYCLE(NB_CYCLE), .N_DRAIN(4)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd(i_cmd),
    .i_step_count(i_step_count),
    .i_halt_detected(i_halt_detected),
    .o_cmd_ready(o_cmd_ready),
    .o_valid(o_valid),
    .o_pipe_reset(o_pipe_reset),
    .o_done(o_done),
    .o_halted(o_halted),
    .o_state(o_state),
    .o_cycle_count(o_cycle_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    bit       cv;
    bit [1:0] cmd;
    bit [7:0] sc;
    bit       halt;
    bit [2:0] es;
    bit       ev;
    bit       er;
    bit       ed;
    bit       ep;
    bit       eh;
    int       ecc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(bit cv, bit [1:0] cmd, bit [7:0] sc,
                              bit halt, bit [2:0] es, bit ed, bit ep,
                              int ecc);
    vec_t v;
    v.cv   = cv;
    v.cmd  = cmd;
    v.sc   = sc;
    v.halt = halt;
    v.es   = es;
    v.ev   = (es == 3'd1) || (es == 3'd2) || (es == 3'd3);
    v.er   = (es == 3'd0) || (es == 3'd1) || (es == 3'd4);
    v.ed   = ed;
    v.ep   = ep;
    v.eh   = (es == 3'd4);
    v.ecc  = CNT_ON ? ecc : 0;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(string tag, vec_t e);
    chk({tag, ".valid"}, 32'(o_valid), 32'(e.ev));
    chk({tag, ".state"}, 32'(o_state), 32'(e.es));
    chk({tag, ".ready"}, 32'(o_cmd_ready), 32'(e.er));
    chk({tag, ".done"}, 32'(o_done), 32'(e.ed));
    chk({tag, ".prst"}, 32'(o_pipe_reset), 32'(e.ep));
    chk({tag, ".halted"}, 32'(o_halted), 32'(e.eh));
    chk({tag, ".ccount"}, 32'(o_cycle_count), 32'(e.ecc));
  endtask

  task automatic drive(bit cv, bit [1:0] cmd, bit [7:0] sc, bit halt);
    i_cmd_valid     = cv;
    i_cmd           = cmd;
    i_step_count    = sc;
    i_halt_detected = halt;
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  always @(negedge i_clock) begin
    if (!i_reset) begin
      checks++;
      if (o_valid && o_pipe_reset) begin
        failures++;
        $display("FAIL excl: valid=%0d pipe_reset=%0d required not both 1",
                 o_valid, o_pipe_reset);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;

    // STEP 3
    tbl.push_back(mk(1, C_STEP, 8'd3, 0, 3'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'd2, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'd2, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 0, 0, 3));
    tbl.push_back(mk(0, C_RUN, 0, 0, 3'd0, 0, 0, 3));
    // STEP 0 acts as 1
    tbl.push_back(mk(1, C_STEP, 8'd0, 0, 3'd2, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 1, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 0, 0, 4));
    tbl.push_back(mk(1, C_CLEAR, 0, 0, 3'd0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(1, C_STOP, 0, 0, 3'd0, 0, 0, 0));
    // RUN, halt and STOP together
    tbl.push_back(mk(1, C_RUN, 0, 0, 3'd1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'd1, 0, 0, 1));
    tbl.push_back(mk(1, C_STOP, 0, 1, 3'd3, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 3'd3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 3'd3, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 3'd3, 0, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 3'd4, 1, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 3'd4, 0, 0, 6));
    tbl.push_back(mk(1, C_RUN, 0, 0, 3'd4, 0, 0, 6));
    tbl.push_back(mk(1, C_STEP, 8'd5, 0, 3'd4, 0, 0, 6));
    tbl.push_back(mk(1, C_STOP, 0, 1, 3'd4, 0, 0, 6));
    tbl.push_back(mk(1, C_CLEAR, 0, 0, 3'd0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 0, 0, 0));
    // RUN 10 cycles, ignored commands mixed in
    tbl.push_back(mk(1, C_RUN, 0, 0, 3'd1, 0, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      bit cv;
      bit [1:0] c;
      cv = (i == 3) || (i == 5) || (i == 7);
      c  = (i == 3) ? C_RUN : (i == 5) ? C_CLEAR : C_STEP;
      tbl.push_back(mk(cv, c, 8'd2, 0, 3'd1, 0, 0, i));
    end
    tbl.push_back(mk(1, C_STOP, 0, 0, 3'd0, 0, 0, 10));
    tbl.push_back(mk(0, 0, 0, 0, 3'd0, 0, 0, 10));
    // counter saturation (4-bit)
    tbl.push_back(mk(1, C_CLEAR, 0, 0, 3'd0, 0, 1, 0));
    tbl.push_back(mk(1, C_RUN, 0, 0, 3'd1, 0, 0, 0));
    for (int i = 1; i <= 20; i++)
      tbl.push_back(mk(0, 0, 0, 0, 3'd1, 0, 0, (i > 15) ? 15 : i));
    tbl.push_back(mk(1, C_STOP, 0, 0, 3'd0, 0, 0, 15));
    // halt during STEP
    tbl.push_back(mk(1, C_CLEAR, 0, 0, 3'd0, 0, 1, 0));
    tbl.push_back(mk(1, C_STEP, 8'd5, 0, 3'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3'd3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3'd3, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 3'd3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 3'd3, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 3'd4, 1, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 3'd4, 0, 0, 5));
    tbl.push_back(mk(1, C_CLEAR, 0, 0, 3'd0, 0, 1, 0));

    // reset state
    #12;
    check_out("reset", mk(0, 0, 0, 0, 3'd0, 0, 0, 0));
    i_reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].cv, tbl[i].cmd, tbl[i].sc, tbl[i].halt);
      exp_q.push_back(tbl[i]);
      tick();
      e = exp_q.pop_front();
      check_out($sformatf("vec%0d", i), e);
    end
    drive(0, 0, 0, 0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // reset in cycle 2 of STEP 5
    drive(1, C_STEP, 8'd5, 0);
    tick();
    drive(0, 0, 0, 0);
    chk("rs_step.state", 32'(o_state), 32'd2);
    tick();
    #2 i_reset = 1'b1;
    #1;
    check_out("rs_step.async", mk(0, 0, 0, 0, 3'd0, 0, 0, 0));
    @(negedge i_clock);
    i_reset = 1'b0;
    tick();
    chk("rs_step.ready", 32'(o_cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rs_step.nodone%0d", i), 32'(o_done), 32'd0);
      chk($sformatf("rs_step.idle%0d", i), 32'(o_state), 32'd0);
      tick();
    end

    // reset mid-DRAIN
    drive(1, C_RUN, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    chk("rs_drain.state", 32'(o_state), 32'd3);
    tick();
    #2 i_reset = 1'b1;
    #1;
    check_out("rs_drain.async", mk(0, 0, 0, 0, 3'd0, 0, 0, 0));
    @(negedge i_clock);
    i_reset = 1'b0;
    tick();
    chk("rs_drain.ready", 32'(o_cmd_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rs_drain.nodone%0d", i), 32'(o_done), 32'd0);
      chk($sformatf("rs_drain.nohalt%0d", i), 32'(o_halted), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
PIPELINE_RUN_CONTROLLER -- requirements
Module: pipeline_run_controller

Interface
REQ-001 The block SHALL have these parameters:
- NB_CMD, default 2, command width.
- NB_STEP, default 8, step-count width.
- NB_CYCLE, default 32, cycle-counter width.
- N_DRAIN, default 4, number of pipeline flush cycles after a halt instruction.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clock, in, 1, single clock; all state updates on its rising edge.
- i_reset, in, 1, reset, asynchronous and active-high.
- i_cmd_valid, in, 1, command offered.
- i_cmd, in, NB_CMD, command: 0=CLEAR, 1=RUN, 2=STEP, 3=STOP.
- i_step_count, in, NB_STEP, cycles to execute for STEP; sampled at accept.
- i_halt_detected, in, 1, halt instruction decoded by the pipeline.
- o_cmd_ready, out, 1, command can be accepted this cycle.
- o_valid, out, 1, pipeline advance enable (drives the stage i_valid inputs).
- o_pipe_reset, out, 1, one-cycle synchronous pipeline clear.
- o_done, out, 1, one-cycle completion pulse.
- o_halted, out, 1, block is in HALTED.
- o_state, out, 3, current state encoding.
- o_cycle_count, out, NB_CYCLE, count of cycles with o_valid=1.

Function
REQ-003 A command SHALL be accepted on a rising edge where i_cmd_valid=1 and o_cmd_ready=1; unaccepted commands SHALL have no effect.
REQ-004 The state machine SHALL have five states with these encodings: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
REQ-005 o_cmd_ready SHALL be 1 in IDLE, RUN and HALTED, and 0 in STEP and DRAIN.
REQ-006 o_valid SHALL be a registered output equal to 1 exactly while the state is RUN, STEP or DRAIN; a command accepted at edge k SHALL change o_valid after edge k.
REQ-007 Transitions from IDLE on an accepted command SHALL be:
- RUN -> RUN.
- STEP -> STEP, with the step counter loaded with i_step_count, where 0 is treated as 1.
- STOP -> remain in IDLE.
- CLEAR -> remain in IDLE, pulse o_pipe_reset for one cycle, clear o_cycle_count.
REQ-008 In RUN, an accepted STOP SHALL move to IDLE; accepted RUN, STEP or CLEAR SHALL be ignored.
REQ-009 In RUN or STEP, i_halt_detected=1 SHALL move to DRAIN with the drain counter loaded to N_DRAIN; if STOP is accepted in the same cycle, halt SHALL take priority.
REQ-010 STEP SHALL keep o_valid=1 for exactly the loaded number of cycles, then return to IDLE and pulse o_done for one cycle.
REQ-011 DRAIN SHALL keep o_valid=1 for exactly N_DRAIN cycles, then enter HALTED and pulse o_done for one cycle; i_halt_detected SHALL be ignored in DRAIN.
REQ-012 HALTED SHALL hold o_valid=0 and o_halted=1; only an accepted CLEAR SHALL exit (to IDLE with an o_pipe_reset pulse), and all other commands SHALL be accepted and ignored.
REQ-013 o_pipe_reset and o_valid SHALL never both be 1 in the same cycle.
REQ-014 The step counter and drain counter SHALL be unsigned and SHALL never wrap below zero.

Reset
REQ-015 Asserting i_reset SHALL immediately force, regardless of the clock:
- state IDLE;
- o_valid=0, o_pipe_reset=0, o_done=0, o_halted=0;
- o_state=0, o_cycle_count=0;
- step and drain counters 0.
REQ-016 Reset asserted mid-STEP or mid-DRAIN SHALL abort the operation with no o_done pulse, and o_cmd_ready SHALL be 1 on the first edge after release.

Configuration
REQ-017 With macro PIPELINE_RUN_CYCLE_COUNTER_EN defined, o_cycle_count SHALL:
- increment by 1 on each edge where o_valid=1;
- saturate at 2^NB_CYCLE-1;
- clear on CLEAR and on reset.
REQ-018 Without PIPELINE_RUN_CYCLE_COUNTER_EN, o_cycle_count SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then STEP with i_step_count=3 -> o_valid high exactly 3 cycles, o_done pulse on the next cycle, state IDLE, o_cycle_count=3 (macro on).
- STEP with i_step_count=0 -> o_valid high exactly 1 cycle, then o_done.
- RUN, then i_halt_detected and STOP in the same cycle -> DRAIN, o_valid high 4 more cycles (N_DRAIN=4), HALTED, o_halted=1, o_done pulse.
- In HALTED, offer RUN -> no change; offer CLEAR -> o_pipe_reset pulse for 1 cycle, IDLE, o_cycle_count=0.
- RUN for 10 cycles, then STOP -> o_valid deasserted after the accepting edge, o_cycle_count=10 (0 with macro off).
- Assert i_reset during cycle 2 of STEP with i_step_count=5 -> o_valid drops immediately, no o_done, o_cmd_ready=1 after release.
